// File: rtl/eq_sweep_pkg.sv
// rtl/eq_sweep_pkg.sv - shared types and default-derived constants for the equivalence sweep controller
package eq_sweep_pkg;

    localparam int N_IN_DEF       = 4;
    localparam int SETTLE_CYC_DEF = 2;

    // Vector space and sweep length for the default configuration
    localparam int NUM_VEC   = 2 ** N_IN_DEF;
    localparam int VEC_LAST  = NUM_VEC - 1;
    localparam int SWEEP_CYC = NUM_VEC * (SETTLE_CYC_DEF + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } sweep_state_t;

endpackage

// File: rtl/sweep_settle_timer.sv
// rtl/sweep_settle_timer.sv - loadable down-counter timing the per-vector hold
module sweep_settle_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] count;

    // Load takes priority; otherwise count down and rest at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/equiv_sweep_ctrl.sv
// rtl/equiv_sweep_ctrl.sv - exhaustive two-implementation sweep comparator; SWEEP_FAIL_MAP_EN adds fail_map_o
module equiv_sweep_ctrl
    import eq_sweep_pkg::*;
#(
    parameter int N_IN       = N_IN_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int CNT_W      = N_IN + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              f_a_i,
    input  logic              f_b_i,
    output logic [N_IN-1:0]   vec_o,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              first_fail_valid,
    output logic [N_IN-1:0]   first_fail_vec
`ifdef SWEEP_FAIL_MAP_EN
    ,
    output logic [2**N_IN-1:0] fail_map_o
`endif
);

    localparam int TW = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;

    sweep_state_t state, state_nxt;
    logic         timer_load;
    logic         expired;
    logic         go_start;
    logic         go_abort;
    logic         cmp_cycle;
    logic         vec_last;
    logic         mismatch;

    assign vec_last = (vec_o == '1);
    assign mismatch = f_a_i ^ f_b_i;

    sweep_settle_timer #(
        .W (TW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (TW'(SETTLE_CYC)),
        .expired  (expired)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, timer reload and datapath strobes; abort beats start
    always_comb begin
        state_nxt  = state;
        timer_load = 1'b0;
        go_start   = 1'b0;
        go_abort   = 1'b0;
        cmp_cycle  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start && !abort) begin
                    state_nxt  = SETTLE;
                    timer_load = 1'b1;
                    go_start   = 1'b1;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_nxt = IDLE;
                    go_abort  = 1'b1;
                end else if (expired) begin
                    cmp_cycle = 1'b1;
                    if (vec_last) begin
                        state_nxt = DONE;
                    end else begin
                        timer_load = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Vector counter and result accumulation; all-ones vector never increments
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_o            <= '0;
            err_cnt          <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
        end else if (go_start) begin
            vec_o            <= '0;
            err_cnt          <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
        end else if (go_abort) begin
            vec_o <= '0;
        end else if (cmp_cycle) begin
            if (mismatch) begin
                err_cnt <= err_cnt + CNT_W'(1);
                if (!first_fail_valid) begin
                    first_fail_valid <= 1'b1;
                    first_fail_vec   <= vec_o;
                end
            end
            if (!vec_last) begin
                vec_o <= vec_o + N_IN'(1);
            end
        end
    end

`ifdef SWEEP_FAIL_MAP_EN
    // Per-vector mismatch bitmap, one bit per input combination
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_map_o <= '0;
        end else if (go_start) begin
            fail_map_o <= '0;
        end else if (cmp_cycle && mismatch) begin
            fail_map_o[vec_o] <= 1'b1;
        end
    end
`endif

    assign busy = (state == SETTLE);
    assign done = (state == DONE);
    assign pass = (state == DONE) && (err_cnt == '0);

endmodule
